// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter. Signal suffixes are from the counter's point of view.
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable_i;
  logic             load_i;
  logic [WIDTH-1:0] load_value_i;
  logic             start_i;
  logic             stop_i;
  logic [WIDTH-1:0] counter_out_o;
  logic             tc_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output enable_i, load_i, load_value_i, start_i, stop_i,
    input  counter_out_o, tc_o, busy_o, done_o
  );

  modport slave (
    input  enable_i, load_i, load_value_i, start_i, stop_i,
    output counter_out_o, tc_o, busy_o, done_o
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Optional auto-reload restarts from the last loaded value instead of stopping at zero.
module down_counter #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.load_i) begin
        count_q  <= bus.load_value_i;
        reload_q <= bus.load_value_i;
        state_q  <= IDLE;
      end else if (bus.stop_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start_i && (count_q != '0)) state_q <= RUN;
          end
          RUN: begin
            if (bus.enable_i) begin
              if (count_q == WIDTH'(1)) begin
                tc_q <= 1'b1;
                if (AUTO_RELOAD) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= DONE;
                end
              end else if (count_q != '0) begin
                // a zero count in RUN holds rather than wrapping to all-ones
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
          DONE: begin
            if (bus.start_i && (reload_q != '0)) begin
              count_q <= reload_q;
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.counter_out_o = count_q;
  assign bus.tc_o          = tc_q;
  assign bus.busy_o        = (state_q == RUN);
  assign bus.done_o        = (state_q == DONE);

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Parameter AUTO_RELOAD, default 0; 1 = restart from reload value at terminal count, 0 = stop at zero.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to clock.
REQ-005 enable  input  1  count qualifier; decrement occurs only in RUN with enable=1.
REQ-006 load  input  1  synchronous load strobe for load_value.
REQ-007 load_value  input  WIDTH  value for counter_out and reload register.
REQ-008 start  input  1  request to enter RUN.
REQ-009 stop  input  1  abort RUN, hold count.
REQ-010 counter_out  output  WIDTH  current count, registered.
REQ-011 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  high while in DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both decoded from registered state.
REQ-015 Input priority per edge: load > stop > start > count.
REQ-016 load=1 in any state: counter_out <= load_value, reload register <= load_value, state <= IDLE, tc <= 0.
REQ-017 IDLE: start=1 with counter_out!=0 -> RUN next edge, count unchanged on that edge; start with counter_out==0 ignored.
REQ-018 RUN, enable=0: counter_out holds, tc <= 0.
REQ-019 RUN, enable=1, counter_out>1: counter_out <= counter_out-1, tc <= 0.
REQ-020 RUN, enable=1, counter_out==1, AUTO_RELOAD=0: counter_out <= 0, tc <= 1, state <= DONE.
REQ-021 RUN, enable=1, counter_out==1, AUTO_RELOAD=1: counter_out <= reload register, tc <= 1, state stays RUN.
REQ-022 tc asserts in the same cycle counter_out first shows 0 (or the reload value); deasserts next cycle unless another terminal count occurs (reload value 1 with AUTO_RELOAD=1 gives tc high every enabled cycle).
REQ-023 RUN, stop=1: state <= IDLE, counter_out holds, tc <= 0.
REQ-024 DONE: start=1 with reload register!=0 -> counter_out <= reload register, state <= RUN; reload register==0 -> start ignored, stay DONE.
REQ-025 DONE, stop=1: state <= IDLE, counter_out stays 0.
REQ-026 Arithmetic is unsigned modulo 2^WIDTH; counter_out never underflows below 0; no wrap from 0 to all-ones under any input.
REQ-027 enable has no effect outside RUN; start in RUN has no effect.

Reset
REQ-028 reset=0: state=IDLE, counter_out=0, reload register=0, tc=0, busy=0, done=0, asynchronously, regardless of clock.
REQ-029 Reset asserted mid-RUN aborts the count; no tc is produced for the aborted run.
REQ-030 First edge after reset release obeys REQ-015..027 normally.

Verification
REQ-031 Reset at t=5, release at t=15; load=1 load_value=4'd5; start; enable=1 -> counter_out 5,4,3,2,1,0; tc high for exactly one cycle at 0; done=1, busy=0 thereafter.
REQ-032 AUTO_RELOAD=1, load 4'd3, start, enable=1 held -> counter_out 3,2,1,3,2,1,...; tc pulses every third enabled cycle, busy stays 1.
REQ-033 In RUN at count 6, toggle enable 1,0,0,1 -> counter_out 5,5,5,4; tc stays 0.
REQ-034 Same cycle load=1 (load_value=4'd9), stop=1, start=1 while in RUN -> counter_out=9, state IDLE, busy=0.
REQ-035 Assert reset asynchronously between clock edges at count 2 -> counter_out=0, busy=0, tc=0 immediately, before the next edge.
REQ-036 From DONE after load 4'd4 run, start=1 -> counter_out=4, busy=1; load 4'd0 then start -> stays IDLE, busy=0.
